// File: rtl/mult_seq_ctrl.sv
// Control FSM for a WIDTH-bit sequential add-shift multiplier driving an external A/B/X datapath.
// Signed mode subtracts on the final multiplier bit; unsigned mode adds on every set bit.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          Load_B,
    input  logic          Signed_Mode,
    input  logic          M,
    output logic          Clr_A,
    output logic          Ld_B,
    output logic          Shift,
    output logic          Add,
    output logic          Sub,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Count
);

    typedef enum logic [2:0] {
        StLoad,
        StCheck,
        StAdd,
        StSub,
        StShift,
        StDone
    } state_e;

    localparam logic [CW-1:0] CountMax = CW'(WIDTH);
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic          signed_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StLoad;
            count_q  <= '0;
            signed_q <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (Run) begin
                        state_q  <= StCheck;
                        count_q  <= '0;
                        signed_q <= Signed_Mode;
                    end
                end
                StCheck: begin
                    // Only the sign bit of the multiplier carries negative weight.
                    if (count_q == CountMax) begin
                        state_q <= StDone;
                    end else if (M && signed_q && (count_q == LastIter)) begin
                        state_q <= StSub;
                    end else if (M) begin
                        state_q <= StAdd;
                    end else begin
                        state_q <= StShift;
                    end
                end
                StAdd, StSub: begin
                    state_q <= StShift;
                end
                StShift: begin
                    count_q <= count_q + CW'(1);
                    state_q <= StCheck;
                end
                StDone: begin
                    if (!Run) begin
                        state_q <= StLoad;
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    always_comb begin
        Clr_A = 1'b0;
        Ld_B  = 1'b0;
        Shift = 1'b0;
        Add   = 1'b0;
        Sub   = 1'b0;
        Busy  = 1'b0;
        Done  = 1'b0;
        Count = count_q;
        if (Reset) begin
            // Hold the datapath cleared and suppress every strobe for the whole reset.
            Clr_A = 1'b1;
            Count = '0;
        end else begin
            case (state_q)
                StLoad: begin
                    Clr_A = Run;
                    Ld_B  = Load_B & ~Run;
                end
                StCheck: begin
                    Busy = 1'b1;
                end
                StAdd: begin
                    Busy = 1'b1;
                    Add  = 1'b1;
                end
                StSub: begin
                    Busy = 1'b1;
                    Sub  = 1'b1;
                end
                StShift: begin
                    Busy  = 1'b1;
                    Shift = 1'b1;
                end
                StDone: begin
                    Done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
